// File: rtl/dark_channel_pkg.sv
// Shared types and helpers for the dark-channel window-minimum filter:
// FSM states, geometry-derived constants, pad value and the min2 comparator.
package dark_channel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_e;

  localparam int MAX_DATA_W = 32;
  typedef logic [MAX_DATA_W-1:0] sample_t;

  // All-ones never wins a minimum, so it doubles as pad and out-of-image value.
  localparam sample_t PAD_VAL = '1;

  function automatic int calc_r(input int win);
    return (win - 1) / 2;
  endfunction

  function automatic int calc_flush_len(input int win, input int img_w);
    return calc_r(win) * img_w + calc_r(win);
  endfunction

  function automatic sample_t min2(input sample_t a, input sample_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/window_line_buffer.sv
// One-line delay for horizontal-minimum values: IMG_W-1 RAM entries plus the
// registered read port give exactly IMG_W advances of delay.
module window_line_buffer #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              en_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o
);

  localparam int DEPTH = IMG_W - 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     addr_q;
  logic [DATA_W-1:0] dout_q;

  // NOTE: the storage array has no reset so it maps onto block RAM; stale
  // contents are hidden by the row masks downstream.
  always_ff @(posedge clock) begin
    if (en_i) begin
      mem_q[addr_q] <= din_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q <= '0;
      dout_q <= '0;
    end else if (en_i) begin
      dout_q <= mem_q[addr_q];
      addr_q <= (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/dark_channel_window_min.sv
// Streaming dark channel: per-pixel channel minimum followed by a WIN x WIN
// window minimum with border masking, frame framing and end-of-frame flush.
module dark_channel_window_min
  import dark_channel_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 3,
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int WIN      = 3
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sof,
  input  logic [CHANNELS*DATA_W-1:0] in_data,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_sof,
  output logic                       out_eof
);

  localparam int R     = calc_r(WIN);
  localparam int FL    = calc_flush_len(WIN, IMG_W);
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(NPIX + FL + 1);
  localparam int FL_W  = $clog2(FL + 1);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H + R + 1);
  localparam logic [DATA_W-1:0] PAD = PAD_VAL[DATA_W-1:0];

  function automatic logic [DATA_W-1:0] min_d(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    return DATA_W'(min2(sample_t'(a), sample_t'(b)));
  endfunction

  // ---------------- input FSM ----------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [FL_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic             advance, take_sof;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    flush_cnt_d = flush_cnt_q;
    in_ready    = (state_q != FLUSH);
    advance     = 1'b0;
    take_sof    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_sof) begin
          advance  = 1'b1;
          take_sof = 1'b1;
          state_d  = RUN;
          in_cnt_d = CNT_W'(1);
        end
      end
      RUN: begin
        if (in_valid) begin
          advance = 1'b1;
          if (in_sof) begin
            take_sof = 1'b1;
            in_cnt_d = CNT_W'(1);
          end else if (in_cnt_q == CNT_W'(NPIX - 1)) begin
            state_d     = FLUSH;
            in_cnt_d    = '0;
            flush_cnt_d = '0;
          end else begin
            in_cnt_d = in_cnt_q + CNT_W'(1);
          end
        end
      end
      FLUSH: begin
        advance = 1'b1;
        if (flush_cnt_q == FL_W'(FL - 1)) begin
          state_d     = IDLE;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + FL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      in_cnt_q    <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // ---------------- stage 1: channel minimum ----------------
  logic [DATA_W-1:0] chan_min;
  logic              s1_valid_q, s1_sof_q;
  logic [DATA_W-1:0] s1_data_q;

  always_comb begin
    chan_min = in_data[DATA_W-1:0];
    for (int c = 1; c < CHANNELS; c++) begin
      chan_min = min_d(chan_min, in_data[c*DATA_W +: DATA_W]);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_sof_q   <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= advance;
      s1_sof_q   <= advance && take_sof;
      if (advance) begin
        s1_data_q <= (state_q == FLUSH) ? PAD : chan_min;
      end
    end
  end

  // ---------------- stage 2: window minimum ----------------
  // Counters track the raster position of the pixel sitting in stage 1; a
  // pending sof restarts them so an aborted frame leaves nothing behind.
  logic [COL_W-1:0]  col_q, col_cur;
  logic [ROW_W-1:0]  row_q, row_cur;
  logic [CNT_W-1:0]  pos_q, pos_cur;
  logic [DATA_W-1:0] hshift_q [2*R];
  logic [DATA_W-1:0] lb_out   [2*R];
  logic [DATA_W-1:0] hmin, vmin;
  logic              out_fire;
  int                cc, rh, hcol, vrow, kidx;

  always_comb begin
    col_cur = s1_sof_q ? '0 : col_q;
    row_cur = s1_sof_q ? '0 : row_q;
    pos_cur = s1_sof_q ? '0 : pos_q;
    // Window centre lags the newest pixel by R raster positions.
    cc   = (int'(col_cur) >= R) ? int'(col_cur) - R : int'(col_cur) + IMG_W - R;
    rh   = (int'(col_cur) >= R) ? int'(row_cur) : int'(row_cur) - 1;
    hcol = 0;
    vrow = 0;
    hmin = (cc + R < IMG_W) ? s1_data_q : PAD;
    for (int j = 1; j < WIN; j++) begin
      hcol = cc + R - j;
      if (hcol >= 0 && hcol < IMG_W) hmin = min_d(hmin, hshift_q[j-1]);
    end
    vmin = (rh >= 0 && rh < IMG_H) ? hmin : PAD;
    for (int i = 1; i < WIN; i++) begin
      vrow = rh - i;
      if (vrow >= 0 && vrow < IMG_H) vmin = min_d(vmin, lb_out[i-1]);
    end
    kidx     = int'(pos_cur) - FL;
    out_fire = s1_valid_q && (kidx >= 0) && (kidx < NPIX);
  end

  for (genvar g = 0; g < 2*R; g++) begin : g_lb
    logic [DATA_W-1:0] lb_in;
    if (g == 0) begin : g_head
      assign lb_in = hmin;
    end else begin : g_tail
      assign lb_in = lb_out[g-1];
    end
    window_line_buffer #(
      .DATA_W(DATA_W),
      .IMG_W (IMG_W)
    ) u_lb (
      .clock (clock),
      .resetn(resetn),
      .en_i  (s1_valid_q),
      .din_i (lb_in),
      .dout_o(lb_out[g])
    );
  end

  logic              out_valid_q, out_sof_q, out_eof_q;
  logic [DATA_W-1:0] out_data_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      col_q       <= '0;
      row_q       <= '0;
      pos_q       <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_data_q  <= '0;
      for (int j = 0; j < 2*R; j++) hshift_q[j] <= '0;
    end else begin
      out_valid_q <= out_fire;
      out_sof_q   <= out_fire && (kidx == 0);
      out_eof_q   <= out_fire && (kidx == NPIX - 1);
      out_data_q  <= out_fire ? vmin : '0;
      if (s1_valid_q) begin
        pos_q <= pos_cur + CNT_W'(1);
        if (col_cur == COL_W'(IMG_W - 1)) begin
          col_q <= '0;
          row_q <= row_cur + ROW_W'(1);
        end else begin
          col_q <= col_cur + COL_W'(1);
          row_q <= row_cur;
        end
        hshift_q[0] <= s1_data_q;
        for (int j = 1; j < 2*R; j++) hshift_q[j] <= hshift_q[j-1];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sof   = out_sof_q;
  assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_dark_channel_window_min.sv
// Scoreboard bench for dark_channel_window_min on a 4x3 image, 3x3 window:
// an independent window model fills the queue, the output monitor drains it.
module tb_dark_channel_window_min;

  localparam int DATA_W   = 8;
  localparam int CHANNELS = 3;
  localparam int IMG_W    = 4;
  localparam int IMG_H    = 3;
  localparam int WIN      = 3;
  localparam int NPIX     = IMG_W * IMG_H;
  localparam int FL       = 5;

  logic                       clock = 1'b0;
  logic                       resetn = 1'b0;
  logic                       in_valid = 1'b0;
  logic                       in_sof = 1'b0;
  logic [CHANNELS*DATA_W-1:0] in_data = '0;
  logic                       in_ready, out_valid, out_sof, out_eof;
  logic [DATA_W-1:0]          out_data;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eof;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          out_seen = 0;
  logic [23:0] frame [NPIX];

  dark_channel_window_min #(
    .DATA_W  (DATA_W),
    .CHANNELS(CHANNELS),
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .WIN     (WIN)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sof   (in_sof),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sof  (out_sof),
    .out_eof  (out_eof)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_px(input int r, input int c);
    logic [7:0] m;
    logic [23:0] w;
    m = 8'hFF;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (r + dr >= 0 && r + dr < IMG_H && c + dc >= 0 && c + dc < IMG_W) begin
          w = frame[(r + dr) * IMG_W + c + dc];
          for (int ch = 0; ch < CHANNELS; ch++) begin
            if (w[ch*8 +: 8] < m) m = w[ch*8 +: 8];
          end
        end
      end
    end
    return m;
  endfunction

  task automatic push_expected(input int n_in, input bit complete);
    int nout;
    exp_t e;
    nout = complete ? NPIX : ((n_in > FL) ? n_in - FL : 0);
    for (int k = 0; k < nout; k++) begin
      e.data = model_px(k / IMG_W, k % IMG_W);
      e.sof  = (k == 0);
      e.eof  = complete && (k == NPIX - 1);
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Called 1ns after a rising edge; the pixel is taken on the next edge.
  task automatic drive_px(input logic [23:0] d, input logic sof);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic fill(input logic [23:0] v);
    for (int k = 0; k < NPIX; k++) frame[k] = v;
  endtask

  task automatic fill_random();
    for (int k = 0; k < NPIX; k++) frame[k] = 24'($urandom);
  endtask

  task automatic run_frame(input string tag, input bit gaps);
    int low;
    push_expected(NPIX, 1'b1);
    for (int k = 0; k < NPIX; k++) begin
      if (gaps && k > 0) idle(1);
      drive_px(frame[k], k == 0);
    end
    low = 0;
    while (!in_ready && low < 50) begin
      low++;
      @(posedge clock);
      #1;
    end
    check({tag, "_flush_len"}, low, FL);
    idle(4);
    check({tag, "_sb_drained"}, sb.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_sof"}, out_sof, 0);
    check({tag, "_out_eof"}, out_eof, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (resetn) begin
      if (!out_valid && (out_sof || out_eof)) check("flag_without_valid", {out_sof, out_eof}, 0);
      if (out_valid) begin
        out_seen++;
        if (sb.size() == 0) begin
          check("unexpected_output", out_data, 32'hDEAD);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_sof", out_sof, e.sof);
          check("out_eof", out_eof, e.eof);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int seen;
    idle(2);
    check_reset_outputs("reset");
    resetn = 1'b1;

    // Non-sof pixels in IDLE are dropped.
    for (int k = 0; k < 3; k++) drive_px(24'h101010, 1'b0);
    idle(8);
    check("nosof_drop", out_seen, 0);

    fill(24'h505050);
    run_frame("flat", 1'b0);

    fill(24'hFFFFFF);
    frame[1*IMG_W + 1] = 24'h401030;
    run_frame("window", 1'b0);

    fill(24'h808080);
    frame[0*IMG_W + 3] = 24'h000000;
    run_frame("border", 1'b0);

    fill(24'h505050);
    run_frame("flat_gaps", 1'b1);

    fill(24'hFFFFFF);
    frame[1*IMG_W + 1] = 24'h401030;
    run_frame("window_gaps", 1'b1);

    // Abort: frame A cut after 6 pixels, frame B follows immediately.
    fill_random();
    push_expected(6, 1'b0);
    for (int k = 0; k < 6; k++) drive_px(frame[k], k == 0);
    fill_random();
    run_frame("abort_b", 1'b0);

    // Reset mid-RUN, also pinning the two-cycle output latency.
    fill(24'h505050);
    for (int k = 0; k < 6; k++) drive_px(frame[k], k == 0);
    check("lat_early", out_valid, 0);
    drive_px(frame[6], 1'b0);
    check("lat_on", out_valid, 1);
    check("lat_data", out_data, 8'h50);
    resetn = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    idle(1);
    resetn = 1'b1;
    seen = out_seen;
    for (int k = 0; k < 4; k++) drive_px(24'h202020, 1'b0);
    idle(8);
    check("post_reset_drop", out_seen, seen);

    fill_random();
    run_frame("recover", 1'b0);

    check("final_sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
